// File: rtl/gb_cpu_common_pkg.sv
// Shared Game Boy CPU definitions: interrupt controller states, IRQ bit indices
// and memory-mapped interrupt register addresses.
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    IRQ_RUN      = 2'd0,
    IRQ_HALT     = 2'd1,
    IRQ_DISPATCH = 2'd2
  } irq_state_t;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [15:0] REG_IF_ADDR = 16'hFF0F;
  localparam logic [15:0] REG_IE_ADDR = 16'hFFFF;

endpackage

// File: rtl/gb_cpu_interrupt_ctrl_if.sv
// Scheduler/CPU-side bundle of the interrupt controller: request strobes,
// IE/IF register access and the dispatch status seen by the control mux.
interface gb_cpu_interrupt_ctrl_if #(parameter int NUM_IRQ = 5);
  logic               instr_boundary;
  logic               ei_request;
  logic               di_request;
  logic               reti_request;
  logic               halt_request;
  logic [NUM_IRQ-1:0] irq;
  logic               reg_wr_en;
  logic               reg_sel;
  logic [7:0]         reg_wr_data;
  logic [7:0]         if_rd_data;
  logic [7:0]         ie_rd_data;
  logic               ime;
  logic               halted;
  logic               int_dispatch;
  logic [2:0]         dispatch_step;
  logic [15:0]        dispatch_vector;
  logic               vector_latched;

  modport master (
    output instr_boundary, ei_request, di_request, reti_request, halt_request,
           irq, reg_wr_en, reg_sel, reg_wr_data,
    input  if_rd_data, ie_rd_data, ime, halted, int_dispatch, dispatch_step,
           dispatch_vector, vector_latched
  );

  modport slave (
    input  instr_boundary, ei_request, di_request, reti_request, halt_request,
           irq, reg_wr_en, reg_sel, reg_wr_data,
    output if_rd_data, ie_rd_data, ime, halted, int_dispatch, dispatch_step,
           dispatch_vector, vector_latched
  );
endinterface

// File: rtl/gb_cpu_irq_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 (VBlank) wins.
module gb_cpu_irq_prio_enc #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Interrupt controller: IME/IE/IF, HALT handling and the 5-M-cycle ISR entry
// sequence that takes over the control mux while int_dispatch is high.
module gb_cpu_interrupt_ctrl
  import gb_cpu_common_pkg::*;
#(
  parameter int          NUM_IRQ     = 5,
  parameter logic [7:0]  VECTOR_BASE = 8'h40
) (
  input logic                    clk,
  input logic                    reset,
  gb_cpu_interrupt_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_IRQ);
  localparam logic [1:0] ST_RUN      = IRQ_RUN;
  localparam logic [1:0] ST_HALT     = IRQ_HALT;
  localparam logic [1:0] ST_DISPATCH = IRQ_DISPATCH;

  logic [1:0]         state;
  logic [2:0]         step;
  logic               ime_q;
  logic [7:0]         ie_q;
  logic [NUM_IRQ-1:0] if_q;
  logic [NUM_IRQ-1:0] if_next;
  logic [NUM_IRQ-1:0] pending;
  logic [7:0]         vec_q;
  logic [7:0]         vec_now;
  logic [IDX_W-1:0]   svc_idx;
  logic               svc_valid;
  logic               in_dispatch;
  logic               step4;
  logic               start_dispatch;

  assign pending     = ie_q[NUM_IRQ-1:0] & if_q;
  assign in_dispatch = (state == ST_DISPATCH);
  assign step4       = in_dispatch && (step == 3'd4);

  gb_cpu_irq_prio_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_prio_enc (
    .req   (pending),
    .idx   (svc_idx),
    .valid (svc_valid)
  );

  assign vec_now = svc_valid ? (VECTOR_BASE + (8'(svc_idx) << 3)) : 8'h00;

  assign start_dispatch = ime_q && (|pending) &&
                          (((state == ST_RUN) && bus.instr_boundary) || (state == ST_HALT));

  // Peripheral pulses are OR'd last so they survive a CPU write or a dispatch clear.
  always_comb begin
    if_next = (bus.reg_wr_en && !bus.reg_sel) ? bus.reg_wr_data[NUM_IRQ-1:0] : if_q;
    if (step4 && svc_valid) if_next[svc_idx] = 1'b0;
    if_next = if_next | bus.irq;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RUN;
      step  <= 3'd0;
      ime_q <= 1'b0;
      ie_q  <= 8'h00;
      if_q  <= '0;
      vec_q <= 8'h00;
    end else begin
      if_q <= if_next;
      if (bus.reg_wr_en && bus.reg_sel) ie_q <= bus.reg_wr_data;

      if (start_dispatch)                         ime_q <= 1'b0;
      else if (!in_dispatch && bus.di_request)    ime_q <= 1'b0;
      else if (bus.reti_request)                  ime_q <= 1'b1;
      else if (!in_dispatch && bus.ei_request)    ime_q <= 1'b1;

      if (step4) vec_q <= vec_now;

      case (state)
        ST_RUN: begin
          if (start_dispatch) begin
            state <= ST_DISPATCH;
            step  <= 3'd1;
          end else if (bus.halt_request) begin
            state <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (start_dispatch) begin
            state <= ST_DISPATCH;
            step  <= 3'd1;
          end else if (|pending) begin
            state <= ST_RUN;
          end
        end
        ST_DISPATCH: begin
          if (step == 3'd5) begin
            state <= ST_RUN;
            step  <= 3'd0;
          end else begin
            step <= step + 3'd1;
          end
        end
        default: begin
          state <= ST_RUN;
          step  <= 3'd0;
        end
      endcase
    end
  end

  assign bus.if_rd_data      = {{(8 - NUM_IRQ){1'b1}}, if_q};
  assign bus.ie_rd_data      = ie_q;
  assign bus.ime             = ime_q;
  assign bus.halted          = (state == ST_HALT);
  assign bus.int_dispatch    = in_dispatch;
  assign bus.dispatch_step   = step;
  assign bus.dispatch_vector = {8'h00, step4 ? vec_now : vec_q};
  assign bus.vector_latched  = step4;

endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
Name: gb_cpu_interrupt_ctrl

Overview:
- Owns IME, IE (0xFFFF), IF (0xFF0F), HALT state and the 5-M-cycle interrupt dispatch sequence.
- Sits directly downstream of the CPU scheduler and consumes its enable_interrupts pulse.
- Samples pending interrupts at every instruction boundary.
- When dispatching, raises int_dispatch so the control mux takes the ISR-entry steps from this block instead of the scheduler.

Parameters:
- NUM_IRQ, 5, number of interrupt sources (VBlank, STAT, Timer, Serial, Joypad; bit 0 is highest priority).
- VECTOR_BASE, 8'h40, vector for bit 0; bit n vector = VECTOR_BASE + 8*n.

Ports:
- clk  input  1  machine (M) clock
- reset  input  1  synchronous, active-low reset (reset==0 resets on the next clk edge)
- instr_boundary  input  1  high during the M-cycle in which the next opcode fetch would be issued
- ei_request  input  1  scheduler's enable_interrupts pulse
- di_request  input  1  DI executed this cycle
- reti_request  input  1  RETI executed this cycle
- halt_request  input  1  HALT executed this cycle
- irq  input  NUM_IRQ  peripheral request pulses, OR'd into IF
- reg_wr_en  input  1  CPU write strobe to IE/IF
- reg_sel  input  1  0 = IF, 1 = IE
- reg_wr_data  input  8  write data
- if_rd_data  output  8  {3'b111, IF}
- ie_rd_data  output  8  IE, all 8 bits stored
- ime  output  1  interrupt master enable
- halted  output  1  CPU halted; fetch suppressed
- int_dispatch  output  1  dispatch sequence active
- dispatch_step  output  3  1..5, current dispatch M-cycle
- dispatch_vector  output  16  {8'h00, vector}; valid from step 4
- vector_latched  output  1  pulses in step 4

Behaviour:
- Reset values: IME=0, IE=8'h00, IF=0, halted=0, int_dispatch=0, dispatch_step=0, dispatch_vector=16'h0000, vector_latched=0.
- pending = IE[NUM_IRQ-1:0] & IF, evaluated from registered values.
- IME update precedence: reset > dispatch start (clear) > di_request (clear) > reti_request (set) > ei_request (set).
  - All updates take effect on the next edge.
  - EI delay is fully provided by the scheduler pulse; no extra delay is added here.
- IF update, per bit, each edge:
  - Step 1: IF = CPU write value if (reg_wr_en & ~reg_sel), else current value.
  - Step 2: clear the bit being serviced in step 4.
  - Step 3: OR in irq. An irq pulse wins over both the CPU clear and the dispatch clear.
- FSM states: RUN, HALT, DISPATCH.
- RUN:
  - instr_boundary & IME & |pending → DISPATCH, step=1, IME cleared on the same edge.
  - halt_request → HALT.
- HALT:
  - halted=1.
  - |pending & IME → DISPATCH.
  - |pending & ~IME → RUN, halted=0 next edge. The HALT bug is not modelled.
  - halt_request is ignored while already halted.
- DISPATCH, steps 1..5, one per M-cycle:
  - Step 1: idle (PC hold).
  - Step 2: SP dec.
  - Step 3: push PCH, SP dec.
  - Step 4: push PCL; priority encode on pending (lowest set bit), latch dispatch_vector, clear that IF bit, pulse vector_latched.
  - Step 5: PC = vector.
  - After step 5 → RUN, int_dispatch=0.
  - Pending is re-sampled in step 4. If it is zero (e.g. the PCH push wrote IE), vector = 16'h0000 and no IF bit is cleared.
- ei_request, di_request, halt_request and instr_boundary are ignored during DISPATCH.
- reset low in any state returns every register to its reset value on that edge, aborting any dispatch.

Decomposition:
- gb_cpu_common_pkg gains:
  - irq_state_t enum {IRQ_RUN, IRQ_HALT, IRQ_DISPATCH}
  - IRQ_VBLANK..IRQ_JOYPAD bit-index constants
  - localparam REG_IF_ADDR = 16'hFF0F, REG_IE_ADDR = 16'hFFFF
- One sub-module: gb_cpu_irq_prio_enc, a combinational lowest-set-bit encoder that produces index and valid.

Test Plan:
- Basic dispatch: IME=1, IE=8'h04; pulse irq[2]; assert instr_boundary → int_dispatch next edge, steps 1..5, step 4 vector=16'h0050, IF[2]=0, IME=0.
- Priority: IME=1, IE=8'h1F, irq bits 4 and 1 set together → vector 16'h0048; IF=5'h10 afterwards.
- HALT exit without IME: IME=0, IE=8'h01; halt_request → halted=1; irq[0] → halted=0 next edge, int_dispatch stays 0.
- IE overwrite quirk: dispatch VBlank; during step 3 write IE=8'h00 → step 4 vector=16'h0000, IF[0] stays 1.
- Simultaneous events:
  - CPU writes IF=8'h00 in the same cycle as irq[3] → if_rd_data=8'hE8.
  - di_request together with ei_request → IME=0.
- Mid-dispatch reset: reset low at step 3 → next edge int_dispatch=0, IE=8'h00, IF=0, IME=0, dispatch_vector=16'h0000.
